// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory/writeback stage.
// Holds the FSM state encoding, the funct3 access codes and the legality check.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Legal means: exactly one of load/store, a valid size code for that
    // direction, and natural alignment for the access size.
    function automatic logic access_ok(
        input logic       is_load,
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [1:0] addr
    );
        logic ok;
        ok = 1'b0;
        if (is_load && !is_store) begin
            case (funct3)
                F3_B, F3_BU: ok = 1'b1;
                F3_H, F3_HU: ok = !addr[0];
                F3_W:        ok = (addr == 2'b00);
                default:     ok = 1'b0;
            endcase
        end else if (is_store && !is_load) begin
            case (funct3)
                F3_B:    ok = 1'b1;
                F3_H:    ok = !addr[0];
                F3_W:    ok = (addr == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load-data lane selection and sign/zero extension.
// Purely combinational; the caller registers the result.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    value = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   value = {24'd0, byte_lane};
            F3_H:    value = {{16{half_lane[15]}}, half_lane};
            F3_HU:   value = {16'd0, half_lane};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory/writeback stage: byte/half/word loads and stores over a req/gnt +
// rvalid handshake, with a registered writeback triple and optional timeout.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_we,
    output logic        mem_fault
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state;
    logic [31:0]     addr_q;
    logic [31:0]     data_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            we_q;
    logic            load_q;
    logic [TO_W-1:0] to_cnt;
    logic [31:0]     load_value;
    logic            ex_mem;
    logic            ex_ok;
    logic            timed_out;

    assign ex_mem    = ex_is_load | ex_is_store;
    assign ex_ok     = access_ok(ex_is_load, ex_is_store, ex_funct3, ex_result[1:0]);
    assign timed_out = (TIMEOUT != 0) && (to_cnt >= TO_LAST);

    // The request side is a function of captured state only, so it stays
    // stable while waiting for the grant.
    assign stall     = (state != IDLE);
    assign dmem_req  = (state == REQ);
    assign dmem_we   = !load_q;
    assign dmem_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        dmem_wdata = data_q;
        dmem_wmask = 4'b0000;
        if (!load_q) begin
            case (f3_q)
                F3_B: begin
                    dmem_wdata = {4{data_q[7:0]}};
                    dmem_wmask = 4'b0001 << addr_q[1:0];
                end
                F3_H: begin
                    dmem_wdata = {2{data_q[15:0]}};
                    dmem_wmask = 4'b0011 << addr_q[1:0];
                end
                default: dmem_wmask = 4'b1111;
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .addr   (addr_q[1:0]),
        .funct3 (f3_q),
        .value  (load_value)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            to_cnt    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            load_q    <= 1'b0;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            wb_rd     <= '0;
            wb_reg_we <= 1'b0;
            mem_fault <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            mem_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        addr_q <= ex_result;
                        data_q <= ex_store_data;
                        f3_q   <= ex_funct3;
                        rd_q   <= ex_rd;
                        we_q   <= ex_reg_we;
                        load_q <= ex_is_load;
                        if (!ex_mem) begin
                            wb_valid  <= 1'b1;
                            wb_data   <= ex_result;
                            wb_rd     <= ex_rd;
                            wb_reg_we <= ex_reg_we && (ex_rd != 5'd0);
                        end else if (!ex_ok) begin
                            wb_valid  <= 1'b1;
                            mem_fault <= 1'b1;
                            wb_rd     <= ex_rd;
                            wb_reg_we <= 1'b0;
                        end else begin
                            state  <= REQ;
                            to_cnt <= '0;
                        end
                    end
                end
                REQ: begin
                    // A grant on the final allowed cycle still completes.
                    if (dmem_gnt) begin
                        to_cnt <= to_cnt + 1'b1;
                        if (load_q) begin
                            state <= RESP;
                        end else begin
                            state     <= IDLE;
                            wb_valid  <= 1'b1;
                            wb_rd     <= rd_q;
                            wb_reg_we <= 1'b0;
                        end
                    end else if (timed_out) begin
                        state     <= IDLE;
                        wb_valid  <= 1'b1;
                        mem_fault <= 1'b1;
                        wb_rd     <= rd_q;
                        wb_reg_we <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        state     <= IDLE;
                        wb_valid  <= 1'b1;
                        wb_data   <= load_value;
                        wb_rd     <= rd_q;
                        wb_reg_we <= we_q && (rd_q != 5'd0);
                    end else if (timed_out) begin
                        state     <= IDLE;
                        wb_valid  <= 1'b1;
                        mem_fault <= 1'b1;
                        wb_rd     <= rd_q;
                        wb_reg_we <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected writebacks and
// memory requests; a monitor and a memory responder compare them.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_result = '0;
    logic [31:0] ex_store_data = '0;
    logic [2:0]  ex_funct3 = '0;
    logic        ex_is_load = 1'b0;
    logic        ex_is_store = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_we = 1'b0;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_we;
    logic        mem_fault;

    mem_stage #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_funct3     (ex_funct3),
        .ex_is_load    (ex_is_load),
        .ex_is_store   (ex_is_store),
        .ex_rd         (ex_rd),
        .ex_reg_we     (ex_reg_we),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wmask    (dmem_wmask),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_reg_we     (wb_reg_we),
        .mem_fault     (mem_fault)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        fault;
        logic        chk_data;
        logic        chk_rd;
        int unsigned due;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        int unsigned gnt_delay;
        logic        give_rvalid;
        int unsigned rv_delay;
        logic [31:0] rdata;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];

    int unsigned stall_cnt = 0;
    int unsigned req_cnt = 0;
    int unsigned wb_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // lat = clock edges from the accept edge's predecessor to the writeback edge
    task automatic expect_wb(input logic [31:0] data, input logic [4:0] rd, input logic we,
                             input logic fault, input logic chk_data, input logic chk_rd,
                             input int unsigned lat);
        wb_exp_t e;
        e.data = data; e.rd = rd; e.we = we; e.fault = fault;
        e.chk_data = chk_data; e.chk_rd = chk_rd; e.due = cyc + lat;
        wb_q.push_back(e);
    endtask

    task automatic expect_req(input logic [31:0] addr, input logic we, input logic [3:0] wmask,
                              input logic [31:0] wdata, input int unsigned gnt_delay,
                              input logic give_rvalid, input int unsigned rv_delay,
                              input logic [31:0] rdata);
        req_exp_t r;
        r.addr = addr; r.we = we; r.wmask = wmask; r.wdata = wdata; r.gnt_delay = gnt_delay;
        r.give_rvalid = give_rvalid; r.rv_delay = rv_delay; r.rdata = rdata;
        req_q.push_back(r);
    endtask

    task automatic issue(input logic [2:0] f3, input logic ld, input logic st,
                         input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input logic we);
        ex_funct3 = f3; ex_is_load = ld; ex_is_store = st; ex_result = res;
        ex_store_data = sd; ex_rd = rd; ex_reg_we = we; ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int unsigned n;
        n = 0;
        while ((wb_q.size() != 0 || req_q.size() != 0 || stall) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, wb_q.size() + req_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_wb_valid"},  wb_valid,  0);
        check({name, "_wb_data"},   wb_data,   0);
        check({name, "_wb_rd"},     wb_rd,     0);
        check({name, "_wb_reg_we"}, wb_reg_we, 0);
        check({name, "_mem_fault"}, mem_fault, 0);
        check({name, "_dmem_req"},  dmem_req,  0);
        check({name, "_stall"},     stall,     0);
    endtask

    initial begin : wb_monitor
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (dmem_req) req_cnt++;
            if (wb_valid) begin
                wb_cnt++;
                if (wb_q.size() == 0) begin
                    check("unexpected_wb", wb_valid, 0);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_cycle",  cyc,       e.due);
                    check("wb_fault",  mem_fault, e.fault);
                    check("wb_reg_we", wb_reg_we, e.we);
                    if (e.chk_rd)   check("wb_rd",   wb_rd,   e.rd);
                    if (e.chk_data) check("wb_data", wb_data, e.data);
                end
            end else if (mem_fault) begin
                check("stray_fault", mem_fault, 0);
            end
        end
    end

    initial begin : mem_responder
        req_exp_t r;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (dmem_req) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", dmem_req, 0);
                end else begin
                    r = req_q.pop_front();
                    check("req_addr",  dmem_addr,  r.addr);
                    check("req_we",    dmem_we,    r.we);
                    check("req_wmask", dmem_wmask, r.wmask);
                    if (r.we) check("req_wdata", dmem_wdata, r.wdata);
                    for (int i = 0; i < int'(r.gnt_delay); i++) begin
                        @(negedge clk);
                        check("req_held", {dmem_req, dmem_wmask, dmem_addr[26:0]},
                              {1'b1, r.wmask, r.addr[26:0]});
                    end
                    dmem_gnt = 1'b1;
                    @(negedge clk);
                    dmem_gnt = 1'b0;
                    if (r.give_rvalid) begin
                        for (int i = 0; i < int'(r.rv_delay); i++) @(negedge clk);
                        dmem_rvalid = 1'b1;
                        dmem_rdata = r.rdata;
                        @(negedge clk);
                        dmem_rvalid = 1'b0;
                        dmem_rdata = '0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int unsigned s;
        int unsigned q;
        int unsigned w;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Non-memory op, latency 1, never stalls
        s = stall_cnt;
        expect_wb(32'h1234_5678, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        issue(3'b000, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
        wait_done("nonmem");
        check("nonmem_stall", stall_cnt - s, 0);

        // SB at 0x1003, grant after two waiting cycles
        s = stall_cnt;
        expect_req(32'h1000, 1'b1, 4'b1000, 32'hABAB_ABAB, 2, 1'b0, 0, 32'h0);
        expect_wb(32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        issue(3'b000, 1'b0, 1'b1, 32'h1003, 32'h0000_00AB, 5'd3, 1'b1);
        wait_done("sb");
        check("sb_stall", stall_cnt - s, 3);

        // SH upper half and SW
        expect_req(32'h1000, 1'b1, 4'b1100, 32'hCDEF_CDEF, 0, 1'b0, 0, 32'h0);
        expect_wb(32'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        issue(3'b001, 1'b0, 1'b1, 32'h1002, 32'h1234_CDEF, 5'd6, 1'b1);
        wait_done("sh");

        expect_req(32'h1004, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1, 1'b0, 0, 32'h0);
        expect_wb(32'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        issue(3'b010, 1'b0, 1'b1, 32'h1004, 32'hDEAD_BEEF, 5'd6, 1'b1);
        wait_done("sw");

        // Loads: minimum latency 3, sign and zero extension
        expect_req(32'h2000, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 0, 32'h0000_8000);
        expect_wb(32'hFFFF_FF80, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        issue(3'b000, 1'b1, 1'b0, 32'h2001, 32'h0, 5'd10, 1'b1);
        wait_done("lb");

        expect_req(32'h2000, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 0, 32'h0000_8000);
        expect_wb(32'h0000_0080, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        issue(3'b100, 1'b1, 1'b0, 32'h2001, 32'h0, 5'd10, 1'b1);
        wait_done("lbu");

        expect_req(32'h2000, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 0, 32'h8001_0000);
        expect_wb(32'hFFFF_8001, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        issue(3'b001, 1'b1, 1'b0, 32'h2002, 32'h0, 5'd11, 1'b1);
        wait_done("lh");

        expect_req(32'h2000, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 0, 32'h8001_0000);
        expect_wb(32'h0000_8001, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        issue(3'b101, 1'b1, 1'b0, 32'h2002, 32'h0, 5'd11, 1'b1);
        wait_done("lhu");

        expect_req(32'h2004, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 1, 32'hCAFE_F00D);
        expect_wb(32'hCAFE_F00D, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 4);
        issue(3'b010, 1'b1, 1'b0, 32'h2004, 32'h0, 5'd7, 1'b1);
        wait_done("lw");

        // rd=0 load never writes
        expect_req(32'h4000, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 0, 32'hFFFF_FFFF);
        expect_wb(32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        issue(3'b010, 1'b1, 1'b0, 32'h4000, 32'h0, 5'd0, 1'b1);
        wait_done("lw_rd0");

        // Illegal accesses: fault next cycle, no request
        s = stall_cnt;
        q = req_cnt;
        expect_wb(32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        issue(3'b010, 1'b1, 1'b0, 32'h3002, 32'h0, 5'd4, 1'b1);
        wait_done("lw_misaligned");
        expect_wb(32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        issue(3'b001, 1'b0, 1'b1, 32'h1001, 32'h5555, 5'd4, 1'b1);
        wait_done("sh_misaligned");
        expect_wb(32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        issue(3'b011, 1'b1, 1'b0, 32'h2000, 32'h0, 5'd4, 1'b1);
        wait_done("load_f3_011");
        expect_wb(32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        issue(3'b100, 1'b0, 1'b1, 32'h1000, 32'h77, 5'd4, 1'b1);
        wait_done("store_f3_100");
        expect_wb(32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        issue(3'b010, 1'b1, 1'b1, 32'h1000, 32'h0, 5'd4, 1'b1);
        wait_done("load_and_store");
        check("illegal_no_req", req_cnt - q, 0);
        check("illegal_stall", stall_cnt - s, 0);

        // Reset while in RESP; the late rvalid lands in IDLE and is dropped
        w = wb_cnt;
        expect_req(32'h2000, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 3, 32'h1111_2222);
        issue(3'b010, 1'b1, 1'b0, 32'h2000, 32'h0, 5'd9, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_state("midop_reset");
        repeat (6) @(posedge clk);
        #1;
        check("midop_no_wb", wb_cnt - w, 0);
        check("midop_wb_data", wb_data, 0);
        check("midop_stall", stall, 0);
        check("midop_req_q", req_q.size(), 0);

        // No rvalid after grant: timeout fault 4 cycles after REQ entry
        expect_req(32'h5000, 1'b0, 4'b0000, 32'h0, 0, 1'b0, 0, 32'h0);
        expect_wb(32'h0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 5);
        issue(3'b010, 1'b1, 1'b0, 32'h5000, 32'h0, 5'd8, 1'b1);
        wait_done("timeout");
        check("timeout_idle", stall, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
